// File: rtl/dmem_bridge.sv
// Processor data-memory port to single-outstanding bus bridge; accesses take 3+ cycles (accept, BUS, RESP).
// op_stall holds the pipeline from request through BUS; a silent bus aborts after TIMEOUT wait cycles.
module dmem_bridge #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ip_data_addr,
    input  logic        ip_data_wr,
    input  logic        ip_data_rd,
    input  logic [3:0]  ip_data_mask,
    input  logic [31:0] ip_data_from_proc,
    output logic        op_data_valid,
    output logic [31:0] op_data_to_proc,
    output logic        op_data_err,
    output logic        op_stall,
    output logic        op_bus_req,
    output logic        op_bus_we,
    output logic [31:0] op_bus_addr,
    output logic [3:0]  op_bus_be,
    output logic [31:0] op_bus_wdata,
    input  logic        ip_bus_ack,
    input  logic [31:0] ip_bus_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [7:0] LP_WAIT_MAX = 8'(TIMEOUT - 1);

    logic [1:0] r_state;
    logic [7:0] r_wait_cnt;

    logic w_req;
    logic w_misalign;

    assign w_req      = ip_data_rd | ip_data_wr;
    // Only full-word accesses can be misaligned; sub-word masks already pick their lanes.
    assign w_misalign = (ip_data_addr[1:0] != 2'b00) && (ip_data_mask == 4'b1111);
    assign op_stall   = !reset && (((r_state == S_IDLE) && w_req) || (r_state == S_BUS));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_wait_cnt      <= 8'd0;
            op_bus_req      <= 1'b0;
            op_bus_we       <= 1'b0;
            op_bus_be       <= 4'b0000;
            op_bus_addr     <= 32'd0;
            op_bus_wdata    <= 32'd0;
            op_data_valid   <= 1'b0;
            op_data_err     <= 1'b0;
            op_data_to_proc <= 32'd0;
        end else begin
            op_data_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        if (w_misalign) begin
                            r_state         <= S_RESP;
                            op_data_valid   <= 1'b1;
                            op_data_err     <= 1'b1;
                            op_data_to_proc <= 32'd0;
                        end else begin
                            r_state      <= S_BUS;
                            r_wait_cnt   <= 8'd0;
                            op_bus_req   <= 1'b1;
                            op_bus_we    <= ip_data_wr;
                            op_bus_addr  <= {ip_data_addr[31:2], 2'b00};
                            op_bus_be    <= ip_data_wr ? ip_data_mask : 4'b1111;
                            op_bus_wdata <= ip_data_from_proc;
                        end
                    end
                end
                S_BUS: begin
                    // Ack is tested first so it wins over a coincident timeout.
                    if (ip_bus_ack) begin
                        r_state         <= S_RESP;
                        op_bus_req      <= 1'b0;
                        op_data_valid   <= 1'b1;
                        op_data_err     <= 1'b0;
                        op_data_to_proc <= op_bus_we ? 32'd0 : ip_bus_rdata;
                    end else if (r_wait_cnt == LP_WAIT_MAX) begin
                        r_state         <= S_RESP;
                        op_bus_req      <= 1'b0;
                        op_data_valid   <= 1'b1;
                        op_data_err     <= 1'b1;
                        op_data_to_proc <= 32'd0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, meaning the maximum number of bus-wait cycles before an access aborts (legal range 2..255).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, a synchronous, active-high reset.
REQ-004 The block SHALL have port ip_data_addr, input, 32, the processor byte address.
REQ-005 The block SHALL have port ip_data_wr, input, 1, the processor store request.
REQ-006 The block SHALL have port ip_data_rd, input, 1, the processor load request.
REQ-007 The block SHALL have port ip_data_mask, input, 4, the processor byte-enable mask for stores.
REQ-008 The block SHALL have port ip_data_from_proc, input, 32, the lane-aligned store data.
REQ-009 The block SHALL have port op_data_valid, output, 1, a one-cycle access-complete pulse.
REQ-010 The block SHALL have port op_data_to_proc, output, 32, the raw load word (the processor performs lane selection and extension).
REQ-011 The block SHALL have port op_data_err, output, 1, qualified by op_data_valid, flagging an aborted or misaligned access.
REQ-012 The block SHALL have port op_stall, output, 1, requiring the processor pipeline to hold.
REQ-013 The block SHALL have ports op_bus_req (output, 1), op_bus_we (output, 1), op_bus_addr (output, 32), op_bus_be (output, 4), op_bus_wdata (output, 32), ip_bus_ack (input, 1) and ip_bus_rdata (input, 32).

Function
REQ-014 The block SHALL implement states IDLE, BUS and RESP.
REQ-015 In IDLE, ip_data_rd or ip_data_wr SHALL latch addr, mask, data and direction and move to BUS on the next edge; if both are set, the access SHALL be treated as a write.
REQ-016 op_stall SHALL be combinational: 1 in IDLE with a request present, 1 in BUS, 0 in RESP, and 0 in IDLE with no request.
REQ-017 The processor holds its request stable while op_stall=1; the block SHALL not re-latch inputs outside IDLE.
REQ-018 In BUS, op_bus_req SHALL be 1, with op_bus_addr={addr[31:2],2'b00}, op_bus_we=latched write, op_bus_be=mask for writes and 4'b1111 for reads, and op_bus_wdata=latched data; all bus outputs SHALL be registered and stable for the whole of BUS.
REQ-019 On ip_bus_ack=1 in BUS, the block SHALL capture ip_bus_rdata (reads only; writes return 0) and go to RESP with err=0.
REQ-020 A wait counter SHALL clear on BUS entry and increment each BUS cycle without ack; at count TIMEOUT-1 without ack, the block SHALL go to RESP with err=1 and data 0.
REQ-021 When ack and the timeout coincide, ack SHALL win (err=0).
REQ-022 RESP SHALL last exactly one cycle: op_data_valid=1, op_bus_req=0, then IDLE.
REQ-023 A request arriving in IDLE on the cycle after RESP SHALL be accepted; the minimum occupancy SHALL be 3 cycles per access (IDLE accept, BUS with immediate ack, RESP).
REQ-024 Misalignment: a write with mask 4'b1111, or a read, with addr[1:0]!=0 and mask 4'b1111 SHALL skip BUS and go IDLE->RESP with err=1 and data 0; byte and halfword masks SHALL never count as misaligned.
REQ-025 op_data_to_proc and op_data_err SHALL hold their last values outside RESP.
REQ-026 A late ip_bus_ack outside BUS SHALL be ignored.

Reset
REQ-027 While reset=1 at an edge: state=IDLE, wait counter=0, op_bus_req=0, op_bus_we=0, op_bus_be=0, op_bus_addr=0, op_bus_wdata=0, op_data_valid=0, op_data_err=0, op_data_to_proc=0.
REQ-028 A reset asserted mid-BUS SHALL abandon the access with no RESP pulse; an ack in the following cycle SHALL be ignored.
REQ-029 op_stall SHALL be 0 during reset.

Verification
REQ-030 Read, addr 0x104, ack after 2 wait cycles with rdata 0xCAFEF00D -> bus_addr 0x104, be 1111, we 0; one valid pulse with 0xCAFEF00D, err 0; stall high 4 cycles.
REQ-031 Byte store, addr 0x203, mask 1000, data 0xAA000000, immediate ack -> bus_addr 0x200, be 1000, we 1, wdata 0xAA000000; valid on cycle 3, err 0.
REQ-032 Read, addr 0x10, never acked, TIMEOUT=16 -> req high 16 cycles, then valid with err 1 and data 0; no req afterward.
REQ-033 Word load, addr 0x106 -> no op_bus_req; valid next cycle with err 1.
REQ-034 Ack coincident with the timeout cycle -> err 0 and captured rdata returned.
REQ-035 Reset during BUS then a stray ack -> no valid pulse, state IDLE, and the next request completes normally.
